// File: rtl/dac_spi_multi.sv
// dac_spi_multi: multi-channel SPI write controller for DAC7554-class DACs.
// One shadow word and one pending flag per channel; pending channels are sent
// one frame at a time in round-robin order over sync/sclk/sdi.
// Optional feature macro: DAC_AUTO_REFRESH_EN. When defined, a free-running
// counter re-marks every channel pending once per REFRESH_CYCLES cycles.
module dac_spi_multi #(
    parameter int WORD_W         = 16,
    parameter int NCH            = 4,
    parameter int CLK_DIV        = 4,
    parameter int CS_SETUP       = 1,
    parameter int CS_HOLD        = 1,
    parameter int CS_GAP         = 2,
    parameter int REFRESH_CYCLES = 1000000,
    localparam int CH_W          = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [WORD_W-1:0] wr_data,
    output logic [NCH-1:0]    pending,
    output logic              busy,
    output logic              frame_done,
    output logic [CH_W-1:0]   done_ch,
    output logic              sync,
    output logic              sdi,
    output logic              sclk
);

    localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                                  : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PH_W    = $clog2(CLK_DIV);
    localparam int BIT_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int HALF    = CLK_DIV / 2;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_e;

    state_e            state_q;
    logic [WORD_W-1:0] shadow_q [NCH];
    logic [NCH-1:0]    pending_q, pending_d;
    logic [WORD_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PH_W-1:0]   phase_q;
    logic [BIT_W-1:0]  bit_q;
    logic [CH_W-1:0]   rr_q, cur_ch_q, done_ch_q, pick;
    logic              found, wr_hit, start, refresh_hit;
    logic              sync_q, sclk_q, sdi_q, busy_q, frame_done_q;

    assign wr_hit = wr_en && (32'(wr_ch) < 32'(NCH));
    assign start  = (state_q == S_IDLE) && found;

    // Round-robin search: first pending channel at or after rr_q, wrapping.
    always_comb begin : pick_search
        logic [CH_W-1:0] cand;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        cand  = '0;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            cand = CH_W'((int'(rr_q) + i) % NCH);
            if (!found && pending_q[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Pending flags: frame-start clear, then host write (write wins), then refresh.
    always_comb begin
        pending_d = pending_q;
        if (start)       pending_d[pick]  = 1'b0;
        if (wr_hit)      pending_d[wr_ch] = 1'b1;
        if (refresh_hit) pending_d        = '1;
    end

    // Host port: shadow words and pending flags.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            pending_q <= '0;
            // NOTE: shadows are reset so a refresh never sends an unwritten, undefined word.
            for (int i = 0; i < NCH; i++) shadow_q[i] <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
            pending_q <= pending_d;
            if (wr_hit) shadow_q[wr_ch] <= wr_data;
        end
    end

`ifdef DAC_AUTO_REFRESH_EN
    localparam int RF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    logic [RF_W-1:0] refresh_q;

    assign refresh_hit = (refresh_q == RF_W'(REFRESH_CYCLES - 1));

    // Free-running refresh period counter.
    always_ff @(posedge clk_in) begin
        if (rst || refresh_hit) refresh_q <= '0;
        else                    refresh_q <= refresh_q + 1'b1;
    end
`else
    assign refresh_hit = 1'b0;
`endif

    // Frame sequencer: IDLE -> SETUP -> SHIFT -> HOLD -> GAP, all outputs registered.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            phase_q      <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            rr_q         <= '0;
            cur_ch_q     <= '0;
            done_ch_q    <= '0;
            sync_q       <= 1'b1;
            sclk_q       <= 1'b0;
            sdi_q        <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        state_q  <= S_SETUP;
                        cnt_q    <= '0;
                        shift_q  <= shadow_q[pick];
                        sdi_q    <= shadow_q[pick][WORD_W-1];
                        cur_ch_q <= pick;
                        sync_q   <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                        state_q <= S_SHIFT;
                        phase_q <= '0;
                        bit_q   <= '0;
                        sclk_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (phase_q == PH_W'(CLK_DIV - 1)) begin
                        phase_q <= '0;
                        if (bit_q == BIT_W'(WORD_W - 1)) begin
                            state_q <= S_HOLD;
                            cnt_q   <= '0;
                        end else begin
                            // Next bit goes out together with the sclk rising edge.
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_q << 1;
                            sdi_q   <= shift_q[WORD_W-2];
                            sclk_q  <= 1'b1;
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                        if (phase_q == PH_W'(HALF - 1)) sclk_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
                        state_q      <= S_GAP;
                        cnt_q        <= '0;
                        sync_q       <= 1'b1;
                        sdi_q        <= 1'b0;
                        frame_done_q <= 1'b1;
                        done_ch_q    <= cur_ch_q;
                        rr_q         <= (cur_ch_q == CH_W'(NCH - 1)) ? '0 : cur_ch_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == CNT_W'(CS_GAP - 1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pending    = pending_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign done_ch    = done_ch_q;
    assign sync       = sync_q;
    assign sdi        = sdi_q;
    assign sclk       = sclk_q;

endmodule

// File: tb/tb_dac_spi_multi.sv
// Self-checking bench for dac_spi_multi: directed scenarios plus random writes,
// with a frame-level reference model and a pin monitor decoding every frame.
module tb_dac_spi_multi;

    localparam int W   = 16;
    localparam int N   = 4;
    localparam int D   = 4;
    localparam int SU  = 1;
    localparam int HO  = 1;
    localparam int GP  = 2;
    localparam int REF = 500;
    localparam int FRAME_LEN = SU + W * D + HO;

    typedef struct {
        int           ch;
        logic [W-1:0] val;
    } frame_t;

    logic         clk_in = 1'b0;
    logic         rst;
    logic         wr_en;
    logic [1:0]   wr_ch;
    logic [W-1:0] wr_data;
    logic [N-1:0] pending;
    logic         busy, frame_done, sync, sdi, sclk;
    logic [1:0]   done_ch;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    logic [W-1:0] m_shadow [N];
    logic [N-1:0] m_pend = '0;
    int           m_rr = 0;
    int           m_refresh = 0;

    // Monitor state
    frame_t       log_q[$];
    bit           prev_s = 1'b1, prev_k = 1'b0, prev_d = 1'b0, want_start = 1'b0;
    int           low_cnt = 0, high_cnt = 1000, pulses = 0, n_start = 0, n_done = 0;
    int           exp_ch = 0;
    logic [W-1:0] exp_val = '0, bits = '0;

    dac_spi_multi #(
        .WORD_W(W), .NCH(N), .CLK_DIV(D), .CS_SETUP(SU), .CS_HOLD(HO),
        .CS_GAP(GP), .REFRESH_CYCLES(REF)
    ) dut (
        .clk_in(clk_in), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .pending(pending), .busy(busy), .frame_done(frame_done), .done_ch(done_ch),
        .sync(sync), .sdi(sdi), .sclk(sclk)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Round-robin choice from the model's pending set; -1 if nothing pending.
    function automatic int pick_model();
        for (int i = 0; i < N; i++) begin
            int c = (m_rr + i) % N;
            if (m_pend[c]) return c;
        end
        return -1;
    endfunction

    // Pin monitor and reference model, evaluated 1 time unit after each edge.
    always @(posedge clk_in) begin : mon
        logic         sw_en, srst, s, k, d, fd, b;
        logic [1:0]   sw_ch, dc;
        logic [W-1:0] sw_d;
        logic [N-1:0] p;
        sw_en = wr_en; sw_ch = wr_ch; sw_d = wr_data; srst = rst;
        #1;
        s = sync; k = sclk; d = sdi; fd = frame_done; b = busy; dc = done_ch; p = pending;
        if (srst) begin
            check("rst_sync", s, 1);    check("rst_sclk", k, 0);  check("rst_sdi", d, 0);
            check("rst_busy", b, 0);    check("rst_fdone", fd, 0);
            check("rst_done_ch", dc, 0); check("rst_pending", p, 0);
            m_pend = '0; m_rr = 0; m_refresh = 0;
            for (int i = 0; i < N; i++) m_shadow[i] = '0;
            high_cnt = 1000; low_cnt = 0; want_start = 1'b0;
        end else begin
            if (prev_s && !s) begin
                check("start_gap", high_cnt >= GP, 1);
                exp_ch = pick_model();
                check("start_has_pending", exp_ch >= 0, 1);
                if (exp_ch >= 0) begin
                    exp_val = m_shadow[exp_ch];
                    m_pend[exp_ch] = 1'b0;
                    m_rr = (exp_ch + 1) % N;
                end else begin
                    exp_val = '0;
                end
                low_cnt = 0; pulses = 0; bits = '0; n_start++;
                check("sdi_msb_at_setup", d, exp_val[W-1]);
            end else if (want_start) begin
                check("start_latency", s, 0);
            end
            if (sw_en && int'(sw_ch) < N) begin
                m_shadow[sw_ch] = sw_d;
                m_pend[sw_ch]   = 1'b1;
            end
`ifdef DAC_AUTO_REFRESH_EN
            if (m_refresh == REF - 1) begin
                m_pend = '1;
                m_refresh = 0;
            end else begin
                m_refresh++;
            end
`endif
            if (!s) begin
                low_cnt++;
                check("busy_in_frame", b, 1);
                check("fdone_in_frame", fd, 0);
                if (k && !prev_k) begin
                    if (pulses == 0) check("setup_len", low_cnt, SU + 1);
                    pulses++;
                end
                if (!k && prev_k) bits = {bits[W-2:0], d};
                if (!prev_s) check("sdi_moves_on_rise", (d !== prev_d) ? (k && !prev_k) : 1'b1, 1);
            end else begin
                if (!prev_s) begin
                    check("frame_len", low_cnt, FRAME_LEN);
                    check("sclk_pulses", pulses, W);
                    check("frame_data", bits, exp_val);
                    check("frame_done", fd, 1);
                    check("done_ch", dc, exp_ch);
                    log_q.push_back('{ch: exp_ch, val: bits});
                    n_done++;
                    high_cnt = 0;
                end else begin
                    check("fdone_idle", fd, 0);
                end
                high_cnt++;
                check("sclk_idle", k, 0);
                check("sdi_idle", d, 0);
                check("busy_gap", b, high_cnt <= GP);
            end
            check("pending", p, m_pend);
            want_start = s && !b && (m_pend != '0);
        end
        prev_s = s; prev_k = k; prev_d = d;
    end

    task automatic write(input int ch, input logic [W-1:0] v);
        @(negedge clk_in);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_data = v;
    endtask

    task automatic wr_off();
        @(negedge clk_in);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || pending != '0) && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        repeat (2) @(negedge clk_in);
        check("drain_idle", {busy, pending}, 0);
    endtask

    task automatic wait_sync_low(input int budget);
        int n = 0;
        while (sync && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        check("sync_low_seen", sync, 0);
    endtask

    task automatic wait_sclk_high(input int budget);
        int n = 0;
        while (!sclk && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        check("sclk_high_seen", sclk, 1);
    endtask

    task automatic expect_log(input int idx, input int ch, input logic [W-1:0] v);
        if (idx < log_q.size()) begin
            check($sformatf("log%0d_ch", idx), log_q[idx].ch, ch);
            check($sformatf("log%0d_val", idx), log_q[idx].val, v);
        end else begin
            check($sformatf("log%0d_present", idx), log_q.size(), idx + 1);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s0, d0;
        rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
        repeat (3) @(negedge clk_in);
        check("reset_sync", sync, 1);
        check("reset_pending", pending, 0);
        check("reset_done_ch", done_ch, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk_in);

`ifndef DAC_AUTO_REFRESH_EN
        // Single frame with write-to-sync latency.
        log_q.delete();
        write(1, 16'h5A3C);
        @(posedge clk_in); #1;
        check("lat_pending_e0", pending, 4'b0010);
        check("lat_sync_e0", sync, 1);
        wr_en = 1'b0;
        @(posedge clk_in); #1;
        check("lat_sync_e1", sync, 0);
        check("lat_busy_e1", busy, 1);
        check("lat_pending_e1", pending, 0);
        wait_idle(300);
        check("single_count", log_q.size(), 1);
        expect_log(0, 1, 16'h5A3C);
        check("done_ch_held", done_ch, 1);

        // Round-robin: writes to 3,0,2 while ch3 is in flight.
        log_q.delete();
        write(3, 16'h0333); wr_off();
        wait_sync_low(20);
        write(3, 16'h3333); write(0, 16'h1000); write(2, 16'h2000); wr_off();
        wait_idle(1000);
        check("rr_count", log_q.size(), 4);
        expect_log(0, 3, 16'h0333);
        expect_log(1, 0, 16'h1000);
        expect_log(2, 2, 16'h2000);
        expect_log(3, 3, 16'h3333);

        // Write to the channel in flight.
        log_q.delete();
        write(2, 16'h1111); wr_off();
        wait_sclk_high(50);
        write(2, 16'h2222); wr_off();
        wait_idle(1000);
        check("inflight_count", log_q.size(), 2);
        expect_log(0, 2, 16'h1111);
        expect_log(1, 2, 16'h2222);

        // Repeated writes collapse.
        log_q.delete();
        write(0, 16'h0F0F); wr_off();
        wait_sclk_high(50);
        write(1, 16'hAAAA); write(1, 16'hBBBB); wr_off();
        wait_idle(1000);
        check("collapse_count", log_q.size(), 2);
        expect_log(0, 0, 16'h0F0F);
        expect_log(1, 1, 16'hBBBB);

        // Reset mid-frame around SHIFT cycle 20.
        log_q.delete();
        write(3, 16'hFFFF); wr_off();
        wait_sclk_high(50);
        write(1, 16'h1234); wr_off();
        repeat (18) @(negedge clk_in);
        rst = 1'b1;
        @(posedge clk_in); #1;
        check("midrst_sync", sync, 1);
        check("midrst_sclk", sclk, 0);
        check("midrst_sdi", sdi, 0);
        check("midrst_fdone", frame_done, 0);
        check("midrst_pending", pending, 0);
        @(negedge clk_in);
        rst = 1'b0;
        repeat (100) @(negedge clk_in);
        check("midrst_no_frame", log_q.size(), 0);
`endif

        // Random writes against the model.
        s0 = n_start; d0 = n_done;
        for (int i = 0; i < 60; i++) begin
            write($urandom_range(0, N - 1), W'($urandom));
            if ($urandom_range(0, 3) != 0) begin
                wr_off();
                repeat ($urandom_range(0, 90)) @(negedge clk_in);
            end
        end
        wr_off();
        wait_idle(3000);
        check("random_frames_balanced", n_done - d0, n_start - s0);
        check("random_some_frames", (n_start - s0) > 10, 1);

`ifdef DAC_AUTO_REFRESH_EN
        s0 = n_start;
        repeat (1400) @(negedge clk_in);
        check("refresh_frames", (n_start - s0) >= 2 * N, 1);
`else
        s0 = n_start;
        repeat (600) @(negedge clk_in);
        check("no_spontaneous_frames", n_start, s0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
